// File: rtl/fb_write_engine_pkg.sv
// rtl/fb_write_engine_pkg.sv - shared defaults and FSM state type for the framebuffer write path
package fb_write_engine_pkg;

  localparam int FB_WORDS_DEF   = 120000;
  localparam int ADDR_WIDTH_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_LATCH = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/fb_write_engine_byte_fifo.sv
// rtl/fb_write_engine_byte_fifo.sv - byte-wide synchronous FIFO with flush
module fb_write_engine_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [PW:0]   wr_q;
  logic [PW:0]   rd_q;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;
  logic [PW-1:0] wr_idx;

  // A flush empties the FIFO first, so a push in the same cycle always fits at slot 0.
  assign do_push = push_i && (flush_i || !full_o);
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign wr_idx  = flush_i ? '0 : wr_q[PW-1:0];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head_o  = mem_q[rd_q[PW-1:0]];

  // Read/write pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= do_push ? PTR_ONE : '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // Storage array; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/fb_write_engine.sv
// rtl/fb_write_engine.sv - buffers pixel bytes and performs one SRAM read-modify-write per byte
module fb_write_engine
  import fb_write_engine_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int FB_WORDS     = FB_WORDS_DEF,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_WAIT    = 3,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  panel_ready,
  output logic                  sram_rd_n,
  output logic                  sram_wr_n,
  output logic                  sram_ce_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [15:0]           sram_wdata,
  input  logic [15:0]           sram_rdata,
  output logic                  busy,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] words_written
);

  localparam logic [2:0]            RD_LAST   = 3'(READ_WAIT - 1);
  localparam logic [2:0]            WR_LAST   = 3'(WRITE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(FB_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            old_q, old_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] words_q, words_d;
  logic                  ovf_q, ovf_d;
  logic                  rd_n_q, wr_n_q, ce_n_q;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_head;
  logic                  unused_rdata_hi;

  // The stored word's high byte is replaced by the old low byte, so it is never read.
  assign unused_rdata_hi = ^sram_rdata[15:8];

  fb_write_engine_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (frame_start),
    .push_i  (byte_valid),
    .data_i  (byte_data),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // RMW sequencing, bus yield on panel_ready low, and frame_start override.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    old_d    = old_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    words_d  = words_q;
    ovf_d    = ovf_q;
    fifo_pop = 1'b0;

    if (byte_valid && fifo_full) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && panel_ready) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        if (!panel_ready) begin
          state_d = ST_IDLE;
        end else if (cnt_q == RD_LAST) begin
          old_d   = sram_rdata[7:0];
          state_d = ST_LATCH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_LATCH: begin
        if (!panel_ready) begin
          state_d = ST_IDLE;
        end else begin
          wdata_d = {old_q, fifo_head};
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!panel_ready) begin
          state_d = ST_IDLE;
        end else if (cnt_q == WR_LAST) begin
          fifo_pop = 1'b1;
          addr_d   = (addr_q == ADDR_LAST) ? '0 : addr_q + ONE;
          if (words_q != '1) words_d = words_q + ONE;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_start) begin
      state_d  = ST_IDLE;
      addr_d   = '0;
      words_d  = '0;
      ovf_d    = 1'b0;
      fifo_pop = 1'b0;
    end
  end

  // State, address, data and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      old_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      old_q   <= old_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
    end
  end

  // Strobes are registered from the next state so the SRAM pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      ce_n_q <= 1'b1;
    end else begin
      rd_n_q <= (state_d != ST_READ);
      wr_n_q <= (state_d != ST_WRITE);
      ce_n_q <= !((state_d == ST_READ) || (state_d == ST_WRITE));
    end
  end

  assign sram_rd_n     = rd_n_q;
  assign sram_wr_n     = wr_n_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign overflow      = ovf_q;
  assign words_written = words_q;
  assign busy          = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_fb_write_engine.sv
// tb/tb_fb_write_engine.sv - scoreboard bench for fb_write_engine
module tb_fb_write_engine;

  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          panel_ready;
  logic          sram_rd_n;
  logic          sram_wr_n;
  logic          sram_ce_n;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata;
  logic [15:0]   sram_rdata;
  logic          busy;
  logic          overflow;
  logic [AW-1:0] words_written;

  logic [15:0]   mem [8];
  logic [33:0]   exp_q [$];
  logic [33:0]   mon_e;
  int            vectors = 0;
  int            miscompares = 0;
  int            wr_pulses = 0;
  int            wr_len = 0;
  int            rd_len = 0;
  int            last_wr_len = 0;
  int            last_rd_len = 0;
  logic          prev_wr_n = 1'b1;
  logic          prev_rd_n = 1'b1;
  logic [AW-1:0] cap_addr;
  logic [15:0]   cap_data;
  int            n0;

  always #5 clk = ~clk;

  assign sram_rdata = mem[sram_addr[2:0]];

  fb_write_engine #(
    .ADDR_WIDTH   (AW),
    .FB_WORDS     (8),
    .FIFO_DEPTH   (4),
    .READ_WAIT    (3),
    .WRITE_CYCLES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .panel_ready   (panel_ready),
    .sram_rd_n     (sram_rd_n),
    .sram_wr_n     (sram_wr_n),
    .sram_ce_n     (sram_ce_n),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .busy          (busy),
    .overflow      (overflow),
    .words_written (words_written)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound of 200 cycles expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tick();
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout_fail(name);
    @(negedge clk);
  endtask

  task automatic wait_rd_low(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (sram_rd_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sram_rd_n) timeout_fail(name);
  endtask

  task automatic wait_wr_low(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (sram_wr_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sram_wr_n) timeout_fail(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_n"},  32'(sram_rd_n), 32'd1);
    check({tag, "_wr_n"},  32'(sram_wr_n), 32'd1);
    check({tag, "_ce_n"},  32'(sram_ce_n), 32'd1);
    check({tag, "_addr"},  32'(sram_addr), 32'd0);
    check({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  // Monitor: memory model, strobe pulse lengths, and scoreboard compare on each completed write.
  always @(negedge clk) begin
    if (!sram_wr_n) begin
      if (prev_wr_n) begin
        wr_len   = 1;
        cap_addr = sram_addr;
        cap_data = sram_wdata;
        wr_pulses++;
      end else begin
        wr_len++;
        check("wr_addr_hold", 32'(sram_addr), 32'(cap_addr));
        check("wr_data_hold", 32'(sram_wdata), 32'(cap_data));
      end
      mem[sram_addr[2:0]] = sram_wdata;
    end else if (!prev_wr_n) begin
      last_wr_len = wr_len;
      if (wr_len == 2) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", cap_addr, cap_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(cap_addr), 32'(mon_e[33:16]));
          check("wr_data", 32'(cap_data), 32'(mon_e[15:0]));
        end
      end
    end
    if (!sram_rd_n) begin
      rd_len = prev_rd_n ? 1 : rd_len + 1;
    end else if (!prev_rd_n) begin
      last_rd_len = rd_len;
    end
    prev_wr_n = sram_wr_n;
    prev_rd_n = sram_rd_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[0] = 16'h00AB; mem[1] = 16'h0021; mem[2] = 16'h0032; mem[3] = 16'h0043;
    mem[4] = 16'h0054; mem[5] = 16'h0065; mem[6] = 16'h0076; mem[7] = 16'h0087;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    panel_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b0;

    // single byte RMW onto 0x00AB
    exp_q.push_back({18'd0, 16'hAB5C});
    send(8'h5C);
    wait_idle("t1");
    check("t1_words", 32'(words_written), 32'd1);
    check("t1_rd_len", 32'(last_rd_len), 32'd3);
    check("t1_wr_len", 32'(last_wr_len), 32'd2);
    check("t1_addr", 32'(sram_addr), 32'd1);

    // five back-to-back bytes into a 4-deep FIFO
    pulse_frame();
    exp_q.push_back({18'd0, 16'h5C01});
    exp_q.push_back({18'd1, 16'h2102});
    exp_q.push_back({18'd2, 16'h3203});
    exp_q.push_back({18'd3, 16'h4304});
    tick();
    byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_data = 8'(8'h01 + i);
      tick();
    end
    byte_valid = 1'b0;
    wait_idle("t2");
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_words", 32'(words_written), 32'd4);
    check("t2_addr", 32'(sram_addr), 32'd4);

    // panel_ready drops in the second READ cycle, then returns
    pulse_frame();
    check("t3_ovf_cleared", 32'(overflow), 32'd0);
    exp_q.push_back({18'd0, 16'h0177});
    send(8'h77);
    wait_rd_low("t3_rd");
    tick();
    panel_ready = 1'b0;
    @(negedge clk);
    check("t3_rd_n_cycle2", 32'(sram_rd_n), 32'd0);
    @(negedge clk);
    check("t3_rd_n_abort", 32'(sram_rd_n), 32'd1);
    check("t3_ce_n_abort", 32'(sram_ce_n), 32'd1);
    n0 = wr_pulses;
    repeat (5) tick();
    check("t3_no_write", 32'(wr_pulses), 32'(n0));
    check("t3_words_held", 32'(words_written), 32'd0);
    panel_ready = 1'b1;
    wait_idle("t3");
    check("t3_words", 32'(words_written), 32'd1);
    check("t3_addr", 32'(sram_addr), 32'd1);

    // address wrap with FB_WORDS = 8
    pulse_frame();
    exp_q.push_back({18'd0, 16'h77A0});
    exp_q.push_back({18'd1, 16'h02A1});
    exp_q.push_back({18'd2, 16'h03A2});
    exp_q.push_back({18'd3, 16'h04A3});
    exp_q.push_back({18'd4, 16'h54A4});
    exp_q.push_back({18'd5, 16'h65A5});
    exp_q.push_back({18'd6, 16'h76A6});
    exp_q.push_back({18'd7, 16'h87A7});
    exp_q.push_back({18'd0, 16'hA0A8});
    for (int i = 0; i < 9; i++) begin
      send(8'(8'hA0 + i));
      wait_idle("t4");
    end
    check("t4_words", 32'(words_written), 32'd9);
    check("t4_addr", 32'(sram_addr), 32'd1);

    // frame_start during WRITE with bytes queued
    pulse_frame();
    tick();
    byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_data = 8'(8'hC1 + i);
      tick();
    end
    byte_valid = 1'b0;
    wait_wr_low("t5_wr");
    check("t5_ovf_before", 32'(overflow), 32'd1);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    @(negedge clk);
    check("t5_wr_n", 32'(sram_wr_n), 32'd1);
    check("t5_ce_n", 32'(sram_ce_n), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_addr", 32'(sram_addr), 32'd0);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_words", 32'(words_written), 32'd0);
    n0 = wr_pulses;
    repeat (10) tick();
    check("t5_no_write", 32'(wr_pulses), 32'(n0));
    check("t5_still_idle", 32'(busy), 32'd0);

    // asynchronous reset in the middle of READ
    send(8'hD1);
    wait_rd_low("t6_rd");
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6");
    n0 = wr_pulses;
    repeat (3) @(negedge clk);
    check("t6_wr_n_in_reset", 32'(sram_wr_n), 32'd1);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t6_no_write", 32'(wr_pulses), 32'(n0));
    check("t6_busy", 32'(busy), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
